// File: rtl/vrf_write_queue_if.sv
// vrf_write_queue_if: writeback push side and arbiter-facing head/grant side of the VRF write queue
interface vrf_write_queue_if #(
  parameter int PORT_NUM   = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 128
);
  logic [PORT_NUM-1:0]            wb_valid;
  logic [PORT_NUM-1:0]            wb_ready;
  logic [PORT_NUM*ADDR_WIDTH-1:0] wb_addr;
  logic [PORT_NUM*DATA_WIDTH-1:0] wb_data;
  logic [PORT_NUM-1:0]            req_valid;
  logic [PORT_NUM*ADDR_WIDTH-1:0] req_addr;
  logic [PORT_NUM*DATA_WIDTH-1:0] req_data;
  logic [PORT_NUM-1:0]            bank_write_select;
  modport master (
    output wb_valid, wb_addr, wb_data, bank_write_select,
    input  wb_ready, req_valid, req_addr, req_data
  );
  modport slave (
    input  wb_valid, wb_addr, wb_data, bank_write_select,
    output wb_ready, req_valid, req_addr, req_data
  );
endinterface

// File: rtl/vrf_write_queue.sv
// vrf_write_queue: per-port FIFO staging writebacks ahead of the VRF bank write arbiters, retiring on grant
module vrf_write_queue #(
  parameter int PORT_NUM     = 2,
  parameter int DEPTH        = 4,
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 128,
  parameter int STARVE_LIMIT = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  vrf_write_queue_if.slave         bus,
  output logic [PORT_NUM-1:0]      starve,
  output logic [PORT_NUM*CW-1:0]   count,
  output logic                     grant_err
);
  logic [PORT_NUM-1:0]            ready;
  logic [PORT_NUM-1:0]            head_v;
  logic [PORT_NUM*ADDR_WIDTH-1:0] head_a;
  logic [PORT_NUM*DATA_WIDTH-1:0] head_d;
  assign bus.wb_ready  = ready;
  assign bus.req_valid = head_v;
  assign bus.req_addr  = head_a;
  assign bus.req_data  = head_d;
  for (genvar g = 0; g < PORT_NUM; g++) begin : g_port
    logic [ADDR_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         rp, wp;
    logic [CW-1:0]         cnt;
    logic [7:0]            sc;
    logic                  push, pop;
    assign ready[g]  = cnt != CW'(DEPTH);
    assign head_v[g] = cnt != '0;
    assign push      = bus.wb_valid[g] & ready[g];
    assign pop       = bus.bank_write_select[g] & head_v[g];
    assign head_a[g*ADDR_WIDTH +: ADDR_WIDTH] = head_v[g] ? mem_a[rp] : '0;
    assign head_d[g*DATA_WIDTH +: DATA_WIDTH] = head_v[g] ? mem_d[rp] : '0;
    assign count[g*CW +: CW] = cnt;
    assign starve[g] = sc >= 8'(STARVE_LIMIT);
    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
      if (push && !flush) begin
        mem_a[wp] <= bus.wb_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        mem_d[wp] <= bus.wb_data[g*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
        sc  <= '0;
      end else begin
        wp  <= push ? wp + 1'b1 : wp;
        rp  <= pop ? rp + 1'b1 : rp;
        cnt <= cnt + CW'(push) - CW'(pop);
        sc  <= (pop || !head_v[g]) ? '0 : sc + {7'd0, sc != 8'hff};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_err <= 1'b0;
    else if (|(bus.bank_write_select & ~head_v)) grant_err <= 1'b1;
  end
endmodule

// File: tb/tb_vrf_write_queue.sv
// tb_vrf_write_queue: directed checks of push/grant/full/starve/flush/reset behaviour
module tb_vrf_write_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0] starve;
  logic [5:0] count;
  logic grant_err;
  int passed = 0;
  int total = 0;
  vrf_write_queue_if #(.PORT_NUM(2), .ADDR_WIDTH(6), .DATA_WIDTH(128)) bus ();
  vrf_write_queue #(.PORT_NUM(2), .DEPTH(4), .ADDR_WIDTH(6), .DATA_WIDTH(128), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave),
    .starve(starve), .count(count), .grant_err(grant_err)
  );
  always #5 clk = ~clk;
  logic [5:0]   a0, a1;
  logic [127:0] d0;
  logic [2:0]   c0, c1;
  assign a0 = bus.req_addr[5:0];
  assign a1 = bus.req_addr[11:6];
  assign d0 = bus.req_data[127:0];
  assign c0 = count[2:0];
  assign c1 = count[5:3];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [5:0] a, input logic [127:0] d);
    bus.wb_valid = 2'b10;
    bus.wb_addr  = {a, 6'd0};
    bus.wb_data  = {d, 128'd0};
    step();
    bus.wb_valid = 2'b00;
  endtask
  task automatic push0(input logic [5:0] a, input logic [127:0] d);
    bus.wb_valid = 2'b01;
    bus.wb_addr  = {6'd0, a};
    bus.wb_data  = {128'd0, d};
    step();
    bus.wb_valid = 2'b00;
  endtask
  initial begin
    bus.wb_valid = '0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.bank_write_select = '0;
    #12;
    chk("rst_ready", bus.wb_ready, 2'b11);
    chk("rst_req_valid", bus.req_valid, 2'b00);
    chk("rst_req_addr", bus.req_addr, 12'd0);
    chk("rst_req_data", bus.req_data, 256'd0);
    chk("rst_starve", starve, 2'b00);
    chk("rst_count", count, 6'd0);
    chk("rst_grant_err", grant_err, 1'b0);
    rst_n = 1'b1;
    step();
    // single push on port 0, visible one cycle later, retired by grant
    bus.wb_valid = 2'b01;
    bus.wb_addr = {6'd0, 6'h05};
    bus.wb_data = {128'd0, 128'hA};
    #1 chk("p0_no_bypass", bus.req_valid[0], 1'b0);
    step();
    bus.wb_valid = 2'b00;
    chk("p0_visible", bus.req_valid[0], 1'b1);
    chk("p0_addr", a0, 6'h05);
    chk("p0_data", d0, 128'hA);
    chk("p0_count1", c0, 3'd1);
    bus.bank_write_select = 2'b01;
    step();
    bus.bank_write_select = 2'b00;
    chk("p0_count0", c0, 3'd0);
    chk("p0_empty", bus.req_valid[0], 1'b0);
    chk("p0_addr_zero", a0, 6'd0);
    chk("no_grant_err", grant_err, 1'b0);
    // fill port 1, fifth push held
    for (int i = 1; i <= 4; i++) push1(6'(i), 128'(16 + i));
    chk("p1_full_count", c1, 3'd4);
    chk("p1_full_ready", bus.wb_ready[1], 1'b0);
    bus.wb_valid = 2'b10;
    bus.wb_addr = {6'd5, 6'd0};
    step();
    chk("p1_held_count", c1, 3'd4);
    chk("p1_head1", a1, 6'd1);
    // full + push + grant: push refused, count 4->3
    bus.bank_write_select = 2'b10;
    chk("p1_full_ready_pop", bus.wb_ready[1], 1'b0);
    step();
    bus.wb_valid = 2'b00;
    chk("p1_count3", c1, 3'd3);
    chk("p1_ready_again", bus.wb_ready[1], 1'b1);
    chk("p1_head2", a1, 6'd2);
    step();
    chk("p1_head3", a1, 6'd3);
    step();
    chk("p1_head4", a1, 6'd4);
    step();
    bus.bank_write_select = 2'b00;
    chk("p1_drained", c1, 3'd0);
    // push+grant at count 2 keeps count, advances head
    push1(6'd7, 128'd7);
    push1(6'd8, 128'd8);
    bus.wb_valid = 2'b10;
    bus.wb_addr = {6'd9, 6'd0};
    bus.bank_write_select = 2'b10;
    step();
    bus.wb_valid = 2'b00;
    chk("p1_pp_count", c1, 3'd2);
    chk("p1_pp_head", a1, 6'd8);
    step();
    chk("p1_pp_head9", a1, 6'd9);
    step();
    bus.bank_write_select = 2'b00;
    chk("p1_pp_drained", c1, 3'd0);
    // starvation on port 0
    push0(6'h20, 128'h20);
    for (int i = 0; i < 7; i++) step();
    chk("starve_before", starve[0], 1'b0);
    step();
    chk("starve_at8", starve[0], 1'b1);
    chk("starve_other", starve[1], 1'b0);
    bus.bank_write_select = 2'b01;
    step();
    bus.bank_write_select = 2'b00;
    chk("starve_cleared", starve[0], 1'b0);
    chk("starve_pop_count", c0, 3'd0);
    // stray grant on empty port 1
    bus.bank_write_select = 2'b10;
    step();
    bus.bank_write_select = 2'b00;
    chk("stray_err", grant_err, 1'b1);
    chk("stray_count", c1, 3'd0);
    step();
    chk("stray_sticky", grant_err, 1'b1);
    // flush with 3 entries, concurrent push discarded
    push0(6'd1, 128'd1);
    push0(6'd2, 128'd2);
    push0(6'd3, 128'd3);
    chk("flush_pre", c0, 3'd3);
    flush = 1'b1;
    bus.wb_valid = 2'b01;
    step();
    flush = 1'b0;
    bus.wb_valid = 2'b00;
    chk("flush_count", count, 6'd0);
    chk("flush_valid", bus.req_valid, 2'b00);
    chk("flush_err_kept", grant_err, 1'b1);
    // async reset mid-cycle
    push0(6'd4, 128'd4);
    chk("ar_pre", c0, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", count, 6'd0);
    chk("ar_valid", bus.req_valid, 2'b00);
    chk("ar_err", grant_err, 1'b0);
    rst_n = 1'b1;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
